// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings, default latencies.
// The MADD/MADDU/MSUB accumulate ops are recognised only when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB);
`else
        return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy covers the full fixed latency of each op.
// Defining MDU_MADD_EN adds the MADD/MADDU/MSUB accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out,
    output logic        dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;

    logic [63:0]       prod_s, prod_u;
    logic [31:0]       quo_s, rem_s, quo_u, rem_u;
    logic              div_ovf;

    // Arithmetic always works on the latched operands so A/B may move during BUSY.
    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'b0, a_q} * {32'b0, b_q};
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quo_s   = '0;
        rem_s   = '0;
        quo_u   = '0;
        rem_u   = '0;
        if (b_q != '0) begin
            quo_u = a_q / b_q;
            rem_u = a_q % b_q;
            if (div_ovf) begin
                quo_s = 32'h8000_0000;
                rem_s = '0;
            end else begin
                quo_s = $signed(a_q) / $signed(b_q);
                rem_s = $signed(a_q) % $signed(b_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (is_mul_op(op) || is_div_op(op))) begin
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = ST_BUSY;
                end else if (op == MDU_MTHI) begin
                    hi_d = A;
                end else if (op == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    case (op_q)
                        MDU_MULT:  {hi_d, lo_d} = prod_s;
                        MDU_MULTU: {hi_d, lo_d} = prod_u;
                        MDU_DIV: begin
                            if (b_q != '0) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        MDU_DIVU: begin
                            if (b_q != '0) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
`ifdef MDU_MADD_EN
                        MDU_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        MDU_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                        MDU_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign dbg_state = state_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign out       = (op == MDU_MFHI) ? hi_q :
                       (op == MDU_MFLO) ? lo_q : 32'h0;

endmodule
